spi_slave_xcvr: RTL and testbench

SPI_SLAVE_XCVR -- requirements
Module: spi_slave_xcvr

---
 rtl/spi_slave_xcvr.sv | 181 ++++++++++++++++++
 tb/tb_spi_slave_xcvr.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_xcvr.sv
// SPI slave transceiver (dclk idles high, shift out on fall, sample on rise, MSB first).
// All serial inputs are resynchronised into the clk domain; supports back-to-back words.
module spi_slave_xcvr #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dclk,
    input  logic             cs,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_load,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             tx_underrun
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

    typedef enum logic {StIdle, StActive} state_e;

    logic dclk_s1, dclk_s2, dclk_d;
    logic cs_s1, cs_s2, cs_d;
    logic mosi_s1, mosi_s2;
    logic dclk_rise, dclk_fall, cs_fall, cs_rise;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] rsh_q, rsh_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             fresh_q, fresh_d;
    logic             pend_q, pend_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             urun_q, urun_d;
    logic             load_start, load_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dclk_s1 <= 1'b1;
            dclk_s2 <= 1'b1;
            dclk_d  <= 1'b1;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_d    <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            dclk_s1 <= dclk;
            dclk_s2 <= dclk_s1;
            dclk_d  <= dclk_s2;
            cs_s1   <= cs;
            cs_s2   <= cs_s1;
            cs_d    <= cs_s2;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    assign dclk_rise = dclk_s2 & ~dclk_d;
    assign dclk_fall = ~dclk_s2 & dclk_d;
    assign cs_fall   = ~cs_s2 & cs_d;
    assign cs_rise   = cs_s2 & ~cs_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        rsh_d       = rsh_q;
        hold_d      = hold_q;
        rx_data_d   = rx_data_q;
        fresh_d     = fresh_q;
        pend_d      = pend_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        urun_d      = 1'b0;
        load_start  = 1'b0;
        load_word   = 1'b0;

        if (tx_load) begin
            hold_d  = tx_data;
            fresh_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d    = StActive;
                    load_start = 1'b1;
                    cnt_d      = '0;
                    pend_d     = 1'b0;
                    // A rising edge seen together with cs_fall is bit 0 of the word.
                    if (dclk_rise) begin
                        rsh_d = {rsh_q[WIDTH-2:0], mosi_s2};
                        cnt_d = CW'(1);
                    end
                end
            end
            StActive: begin
                if (cs_rise) begin
                    state_d = StIdle;
                    pend_d  = 1'b0;
                    cnt_d   = '0;
                    if (cnt_q != '0) frame_err_d = 1'b1;
                end else begin
                    if (dclk_rise) begin
                        rsh_d = {rsh_q[WIDTH-2:0], mosi_s2};
                        if (cnt_q == '0 && pend_q) begin
                            urun_d = 1'b1;
                            pend_d = 1'b0;
                        end
                        if (cnt_q == LastBit) begin
                            rx_data_d  = {rsh_q[WIDTH-2:0], mosi_s2};
                            rx_valid_d = 1'b1;
                            cnt_d      = '0;
                            load_word  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    if (dclk_fall && cnt_q != '0) begin
                        sh_d = {sh_q[WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A word-boundary reload only counts as underrun once the next word really starts.
        if (load_start || load_word) begin
            sh_d    = tx_load ? tx_data : hold_q;
            fresh_d = 1'b0;
            if (!tx_load && !fresh_q) begin
                if (load_start) urun_d = 1'b1;
                else            pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            sh_q        <= '0;
            rsh_q       <= '0;
            hold_q      <= '0;
            rx_data_q   <= '0;
            fresh_q     <= 1'b0;
            pend_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            urun_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            rsh_q       <= rsh_d;
            hold_q      <= hold_d;
            rx_data_q   <= rx_data_d;
            fresh_q     <= fresh_d;
            pend_q      <= pend_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            urun_q      <= urun_d;
        end
    end

    assign busy        = (state_q == StActive);
    assign miso        = busy ? sh_q[WIDTH-1] : 1'b1;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign tx_underrun = urun_q;

endmodule

// File: tb/tb_spi_slave_xcvr.sv
// Self-checking bench for spi_slave_xcvr: bench acts as SPI master at clk/8,
// expected rx and miso words are queued when driven and compared when produced.
module tb_spi_slave_xcvr;

    logic        clk = 1'b0;
    logic        rst;
    logic        dclk, cs, mosi, miso;
    logic [15:0] tx_data, rx_data;
    logic        tx_load, rx_valid, busy, frame_err, tx_underrun;

    int checks = 0;
    int errors = 0;
    int rxv_cnt = 0, ferr_cnt = 0, urun_cnt = 0;
    logic [15:0] exp_rx[$];
    logic [15:0] exp_tx[$];

    always #5 clk = ~clk;

    spi_slave_xcvr #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .dclk(dclk), .cs(cs), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .frame_err(frame_err), .tx_underrun(tx_underrun)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Passive monitor: each cycle with rx_valid high consumes one expected word.
    initial forever begin
        @(negedge clk);
        if (rx_valid) begin
            rxv_cnt++;
            if (exp_rx.size() > 0) check_eq("rx_data", rx_data, exp_rx.pop_front());
            else                   check_eq("rx_extra", rx_valid, 0);
        end
        if (frame_err)   ferr_cnt++;
        if (tx_underrun) urun_cnt++;
    end

    task automatic load(input logic [15:0] w);
        @(negedge clk);
        tx_data = w;
        tx_load = 1'b1;
        exp_tx.push_back(w);
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic frame_begin();
        @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_end();
        cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic xfer(input logic [15:0] w, input int nbits, output logic [15:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            dclk = 1'b0;
            mosi = w[15-i];
            repeat (4) @(negedge clk);
            got  = {got[14:0], miso};
            dclk = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic check_miso(input logic [15:0] got);
        if (exp_tx.size() > 0) check_eq("miso_word", got, exp_tx.pop_front());
        else                   check_eq("miso_noexp", exp_tx.size(), 1);
    endtask

    initial begin
        logic [15:0] got;
        int rx0, fe0, ur0;
        rst = 1'b1; dclk = 1'b1; cs = 1'b1; mosi = 1'b0; tx_load = 1'b0; tx_data = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_miso", miso, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rx_data", rx_data, 0);
        check_eq("rst_pulses", {rx_valid, frame_err, tx_underrun}, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single frame
        load(16'hA5C3);
        exp_rx.push_back(16'h3C5A);
        frame_begin();
        check_eq("busy_active", busy, 1);
        xfer(16'h3C5A, 16, got);
        check_miso(got);
        frame_end();
        check_eq("busy_after", busy, 0);
        check_eq("single_rxv", rxv_cnt, 1);
        check_eq("single_urun", urun_cnt, 0);

        // Back-to-back words, second tx word loaded mid first word
        load(16'h0F0F);
        exp_rx.push_back(16'h1234);
        exp_rx.push_back(16'hABCD);
        rx0 = rxv_cnt;
        frame_begin();
        fork
            xfer(16'h1234, 16, got);
            begin
                repeat (20) @(negedge clk);
                load(16'hF0F0);
            end
        join
        check_miso(got);
        xfer(16'hABCD, 16, got);
        check_miso(got);
        frame_end();
        check_eq("b2b_rxv", rxv_cnt - rx0, 2);
        check_eq("b2b_urun", urun_cnt, 0);

        // Abort after 7 bits
        rx0 = rxv_cnt; fe0 = ferr_cnt;
        frame_begin();
        xfer(16'h7777, 7, got);
        frame_end();
        check_eq("abort_ferr", ferr_cnt - fe0, 1);
        check_eq("abort_rxv", rxv_cnt - rx0, 0);
        check_eq("abort_rx_keep", rx_data, 16'hABCD);
        check_eq("abort_busy", busy, 0);

        // Underrun: one load, two frames
        load(16'h8001);
        exp_tx.push_back(16'h8001);
        exp_rx.push_back(16'h1357);
        exp_rx.push_back(16'h2468);
        ur0 = urun_cnt;
        frame_begin();
        xfer(16'h1357, 16, got);
        check_miso(got);
        frame_end();
        check_eq("urun_first", urun_cnt - ur0, 0);
        frame_begin();
        check_eq("urun_start", urun_cnt - ur0, 1);
        xfer(16'h2468, 16, got);
        check_miso(got);
        frame_end();
        check_eq("urun_total", urun_cnt - ur0, 1);

        // Reset mid-frame after 9 bits
        @(negedge clk);
        tx_data = 16'h1111; tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        fe0 = ferr_cnt;
        frame_begin();
        xfer(16'hFFFF, 9, got);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_miso", miso, 1);
        check_eq("mid_rst_rx", rx_data, 0);
        cs = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("mid_rst_ferr", ferr_cnt - fe0, 0);
        load(16'h2222);
        exp_rx.push_back(16'h5A5A);
        rx0 = rxv_cnt;
        frame_begin();
        xfer(16'h5A5A, 16, got);
        check_miso(got);
        frame_end();
        check_eq("post_rst_rxv", rxv_cnt - rx0, 1);

        // Idle noise on dclk with cs high
        rx0 = rxv_cnt;
        for (int i = 0; i < 20; i++) begin
            dclk = ~dclk;
            repeat (4) @(negedge clk);
            check_eq("idle_busy_miso", {busy, miso}, 2'b01);
        end
        check_eq("idle_rxv", rxv_cnt - rx0, 0);

        check_eq("rx_pending", exp_rx.size(), 0);
        check_eq("tx_pending", exp_tx.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
